// File: rtl/types_def.sv
// types_def: request/burst types and default widths shared by the burst path
package types_def;
  localparam int address_width = 16;
  localparam int data_width = 32;
  localparam int read_entries_log = 4;
  typedef logic [address_width-1:0] address_type;
  typedef enum logic {R_READ = 1'b0, R_WRITE = 1'b1} r_type;
  typedef enum logic [2:0] {
    B_EMPTY     = 3'd0,
    B_STARTED   = 3'd1,
    B_ALMOST    = 3'd2,
    B_FULL      = 3'd3,
    B_RETURNING = 3'd4
  } burst_states_type;
endpackage

// File: rtl/burst_prio_enc.sv
// burst_prio_enc: lowest set bit of req as one-hot, binary id and any flag
module burst_prio_enc #(
  parameter int W = 4,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req,
  output logic [W-1:0]  onehot,
  output logic [IW-1:0] id,
  output logic          any
);
  always_comb begin
    onehot = req & (~req + W'(1));
    any = |req;
    id = '0;
    for (int i = W - 1; i >= 0; i--) id = req[i] ? IW'(i) : id;
  end
endmodule

// File: rtl/burst_collector.sv
// burst_collector: merges arbiter requests into NB burst slots, captures read beats, drains requests to the returner
module burst_collector
  import types_def::*;
#(
  parameter int NB = 4,
  parameter int BL = 16,
  parameter int ADDR_W = address_width,
  parameter int DATA_W = data_width,
  parameter int IDX_W = read_entries_log,
  parameter int ALMOST_TH = 8,
  parameter int FILL_TIMEOUT = 2,
  localparam int LB = $clog2(BL),
  localparam int BA_W = ADDR_W - LB,
  localparam int SW = $clog2(NB),
  localparam int CW = LB + 1,
  localparam int ECW = SW + 1,
  localparam int TW = (FILL_TIMEOUT > 0) ? $clog2(FILL_TIMEOUT + 1) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             arb_valid,
  output logic                             arb_ready,
  input  logic [ADDR_W-1:0]                arb_address,
  input  r_type                            arb_type,
  input  logic [DATA_W-1:0]                arb_data,
  input  logic [IDX_W-1:0]                 arb_index,
  output burst_states_type [NB-1:0]        burst_state,
  output r_type [NB-1:0]                   burst_type,
  output logic [NB-1:0][BA_W-1:0]          burst_address,
  output logic [ECW-1:0]                   empty_count,
  input  logic                             done_valid,
  input  logic [SW-1:0]                    done_burst,
  input  logic                             mem_rd_valid,
  input  logic [SW-1:0]                    mem_rd_burst,
  input  logic [LB-1:0]                    mem_rd_beat,
  input  logic [DATA_W-1:0]                mem_rd_data,
  input  logic                             mem_rd_last,
  output logic                             ret_valid,
  input  logic                             ret_ready,
  output r_type                            ret_type,
  output logic [DATA_W-1:0]                ret_data,
  output logic [IDX_W-1:0]                 ret_index
);
  typedef struct packed {
    burst_states_type              st;
    r_type                         ty;
    logic [BA_W-1:0]               addr;
    logic [BL-1:0]                 mask;
    logic [CW-1:0]                 cnt;
    logic                          done;
    logic [BL-1:0][DATA_W-1:0]     data;
    logic [BL-1:0][IDX_W-1:0]      idx;
  } slot_t;
  slot_t slot [NB];
  logic open_vld;
  logic [SW-1:0] open_id;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] ret_slot;
  logic [BL-1:0] ret_oh;
  logic [LB-1:0] col;
  logic [BA_W-1:0] row;
  logic match, acc, merge, alloc, timeout, hs, last_bit, load, rd_ok;
  logic [CW-1:0] cnt_nx;
  logic [NB-1:0] e_req, e_oh, c_req, c_oh;
  logic [SW-1:0] e_id, c_id;
  logic e_any, c_any, m_any;
  logic [BL-1:0] mask_eff [NB];
  logic [BL-1:0] sel_mask, m_oh;
  logic [LB-1:0] m_id;
  burst_prio_enc #(.W(NB)) u_empty (.req(e_req), .onehot(e_oh), .id(e_id), .any(e_any));
  burst_prio_enc #(.W(NB)) u_ret (.req(c_req), .onehot(c_oh), .id(c_id), .any(c_any));
  burst_prio_enc #(.W(BL)) u_col (.req(sel_mask), .onehot(m_oh), .id(m_id), .any(m_any));
  // the entry already sitting in the ret_* registers is hidden from the next selection
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      e_req[i] = slot[i].st == B_EMPTY;
      mask_eff[i] = slot[i].mask & ~((ret_valid && ret_slot == SW'(i)) ? ret_oh : '0);
      c_req[i] = slot[i].st == B_RETURNING && mask_eff[i] != '0;
      burst_state[i] = slot[i].st;
      burst_type[i] = slot[i].ty;
      burst_address[i] = slot[i].addr;
    end
  end
  always_comb begin
    col = arb_address[LB-1:0];
    row = arb_address[ADDR_W-1:LB];
    match = open_vld && slot[open_id].addr == row && slot[open_id].ty == arb_type && !slot[open_id].mask[col];
    arb_ready = match || e_any;
    acc = arb_valid && arb_ready;
    merge = acc && match;
    alloc = acc && !match;
    cnt_nx = slot[open_id].cnt + CW'(1);
    timeout = !acc && open_vld && int'(tcnt) + 1 >= FILL_TIMEOUT;
    hs = ret_valid && ret_ready;
    last_bit = (slot[ret_slot].mask & ~ret_oh) == '0;
    rd_ok = mem_rd_valid && slot[mem_rd_burst].st == B_FULL && slot[mem_rd_burst].ty == R_READ && slot[mem_rd_burst].done;
    load = (!ret_valid || ret_ready) && c_any && m_any;
    sel_mask = '0;
    for (int i = 0; i < NB; i++) sel_mask = sel_mask | (c_oh[i] ? mask_eff[i] : '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) slot[i] <= '0;
      open_vld <= 1'b0;
      open_id <= '0;
      tcnt <= '0;
      ret_valid <= 1'b0;
      ret_slot <= '0;
      ret_oh <= '0;
      ret_type <= R_READ;
      ret_data <= '0;
      ret_index <= '0;
      empty_count <= ECW'(NB);
    end else begin
      tcnt <= acc ? '0 : (int'(tcnt) >= FILL_TIMEOUT ? tcnt : tcnt + TW'(1));
      if (timeout) begin
        slot[open_id].st <= B_FULL;
        open_vld <= 1'b0;
      end
      if (merge) begin
        slot[open_id].mask[col] <= 1'b1;
        slot[open_id].idx[col] <= arb_index;
        if (arb_type == R_WRITE) slot[open_id].data[col] <= arb_data;
        slot[open_id].cnt <= cnt_nx;
        if (cnt_nx == CW'(BL)) begin
          slot[open_id].st <= B_FULL;
          open_vld <= 1'b0;
        end else if (cnt_nx == CW'(ALMOST_TH)) slot[open_id].st <= B_ALMOST;
      end
      if (alloc) begin
        if (open_vld) slot[open_id].st <= B_FULL;
        for (int i = 0; i < NB; i++) begin
          if (e_oh[i]) begin
            slot[i].st <= B_STARTED;
            slot[i].ty <= arb_type;
            slot[i].addr <= row;
            slot[i].mask <= BL'(1) << col;
            slot[i].cnt <= CW'(1);
            slot[i].done <= 1'b0;
            slot[i].idx[col] <= arb_index;
            if (arb_type == R_WRITE) slot[i].data[col] <= arb_data;
          end
        end
        open_vld <= 1'b1;
        open_id <= e_id;
      end
      // reads stay full after service until the last beat arrives
      if (done_valid && slot[done_burst].st == B_FULL) begin
        if (slot[done_burst].ty == R_WRITE) slot[done_burst].st <= B_RETURNING;
        else slot[done_burst].done <= 1'b1;
      end
      if (rd_ok) begin
        if (slot[mem_rd_burst].mask[mem_rd_beat]) slot[mem_rd_burst].data[mem_rd_beat] <= mem_rd_data;
        if (mem_rd_last) slot[mem_rd_burst].st <= B_RETURNING;
      end
      if (hs) begin
        slot[ret_slot].mask <= slot[ret_slot].mask & ~ret_oh;
        if (last_bit) slot[ret_slot].st <= B_EMPTY;
      end
      if (load) begin
        ret_slot <= c_id;
        ret_oh <= m_oh;
        ret_type <= slot[c_id].ty;
        ret_data <= slot[c_id].data[m_id];
        ret_index <= slot[c_id].idx[m_id];
      end
      ret_valid <= load || (ret_valid && !ret_ready);
      empty_count <= empty_count + ECW'(hs && last_bit) - ECW'(alloc);
    end
  end
endmodule

// File: tb/tb_burst_collector.sv
// tb_burst_collector: directed and randomized checks of burst_collector against a burst-level model
module tb_burst_collector;
  import types_def::*;
  localparam int NB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arb_valid = 1'b0;
  logic arb_ready;
  logic [15:0] arb_address = '0;
  r_type arb_type = R_READ;
  logic [31:0] arb_data = '0;
  logic [3:0] arb_index = '0;
  burst_states_type [NB-1:0] burst_state;
  r_type [NB-1:0] burst_type;
  logic [NB-1:0][11:0] burst_address;
  logic [2:0] empty_count;
  logic done_valid = 1'b0;
  logic [1:0] done_burst = '0;
  logic mem_rd_valid = 1'b0;
  logic [1:0] mem_rd_burst = '0;
  logic [3:0] mem_rd_beat = '0;
  logic [31:0] mem_rd_data = '0;
  logic mem_rd_last = 1'b0;
  logic ret_valid;
  logic ret_ready = 1'b1;
  r_type ret_type;
  logic [31:0] ret_data;
  logic [3:0] ret_index;
  int total = 0;
  int bad = 0;
  logic [3:0] e_idx [16];
  logic [31:0] e_dat [16];
  logic [3:0] i3 [4];
  logic [31:0] d3 [4];
  burst_collector dut (
    .clk(clk), .rst(rst),
    .arb_valid(arb_valid), .arb_ready(arb_ready), .arb_address(arb_address),
    .arb_type(arb_type), .arb_data(arb_data), .arb_index(arb_index),
    .burst_state(burst_state), .burst_type(burst_type), .burst_address(burst_address),
    .empty_count(empty_count), .done_valid(done_valid), .done_burst(done_burst),
    .mem_rd_valid(mem_rd_valid), .mem_rd_burst(mem_rd_burst), .mem_rd_beat(mem_rd_beat),
    .mem_rd_data(mem_rd_data), .mem_rd_last(mem_rd_last),
    .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_type(ret_type),
    .ret_data(ret_data), .ret_index(ret_index)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [11:0] row, input logic [3:0] c, input logic t, input logic [31:0] d, input logic [3:0] ix);
    arb_valid = 1'b1;
    arb_address = {row, c};
    arb_type = r_type'(t);
    arb_data = d;
    arb_index = ix;
    tick;
    arb_valid = 1'b0;
  endtask
  task automatic svc(input int s);
    done_valid = 1'b1;
    done_burst = 2'(s);
    tick;
    done_valid = 1'b0;
  endtask
  task automatic wait_ret;
    for (int n = 0; n < 32 && !ret_valid; n++) tick;
  endtask
  task automatic expect_ret(input logic t, input logic [3:0] ix, input logic [31:0] d);
    wait_ret;
    check("ret_valid", ret_valid, 1'b1);
    check("ret_type", ret_type, t);
    check("ret_index", ret_index, ix);
    check("ret_data", ret_data, d);
    tick;
  endtask
  task automatic check_reset(input string tag);
    for (int s = 0; s < NB; s++) begin
      check({tag, "_state"}, burst_state[s], B_EMPTY);
      check({tag, "_addr"}, burst_address[s], 12'h0);
    end
    check({tag, "_empty_count"}, empty_count, 3'd4);
    check({tag, "_ret_valid"}, ret_valid, 1'b0);
    check({tag, "_arb_ready"}, arb_ready, 1'b1);
  endtask
  task automatic burst(input logic [11:0] row, input logic t, input logic [15:0] m, input bit shuf);
    int ord[$];
    int n;
    for (int c = 0; c < 16; c++) if (m[c]) ord.push_back(c);
    if (shuf) begin
      for (int i = ord.size() - 1; i > 0; i--) begin
        int j = int'($urandom_range(i, 0));
        int x = ord[i];
        ord[i] = ord[j];
        ord[j] = x;
      end
    end
    n = 0;
    foreach (ord[k]) begin
      e_idx[ord[k]] = 4'($urandom);
      e_dat[ord[k]] = $urandom;
      send(row, 4'(ord[k]), t, e_dat[ord[k]], e_idx[ord[k]]);
      n++;
      check("fill_state", burst_state[0], n == 16 ? B_FULL : n >= 8 ? B_ALMOST : B_STARTED);
    end
    if (n < 16) begin
      tick;
      check("idle1_state", burst_state[0], n >= 8 ? B_ALMOST : B_STARTED);
      tick;
      check("timeout_full", burst_state[0], B_FULL);
    end
    check("burst_type", burst_type[0], t);
    check("burst_address", burst_address[0], row);
    check("fill_empty_count", empty_count, 3'd3);
    svc(0);
    check("after_done", burst_state[0], t ? B_RETURNING : B_FULL);
    if (!t) begin
      for (int b = 0; b < 16; b++) begin
        logic [31:0] d = $urandom;
        mem_rd_valid = 1'b1;
        mem_rd_burst = 2'd0;
        mem_rd_beat = 4'(b);
        mem_rd_data = d;
        mem_rd_last = (b == 15);
        if (m[b]) e_dat[b] = d;
        tick;
      end
      mem_rd_valid = 1'b0;
      mem_rd_last = 1'b0;
      check("after_last", burst_state[0], B_RETURNING);
    end
    for (int c = 0; c < 16; c++) if (m[c]) expect_ret(t, e_idx[c], e_dat[c]);
    check("drained_state", burst_state[0], B_EMPTY);
    check("drained_ret_valid", ret_valid, 1'b0);
    check("drained_empty_count", empty_count, 3'd4);
  endtask
  initial begin
    tick;
    tick;
    rst = 1'b0;
    check_reset("reset");
    // 16 writes to one row fill slot 0 in column order
    burst(12'h012, 1'b1, 16'hFFFF, 1'b0);
    // write then read of the same address cannot merge; cols 2 and 9 merge into the read slot
    send(12'h0AB, 4'd3, 1'b1, 32'hD3, 4'd5);
    send(12'h0AB, 4'd2, 1'b0, 32'h0, 4'd2);
    check("type_split_s0", burst_state[0], B_FULL);
    check("type_split_s1", burst_state[1], B_STARTED);
    check("type_split_ec", empty_count, 3'd2);
    send(12'h0AB, 4'd9, 1'b0, 32'h0, 4'd9);
    check("merge_s1", burst_state[1], B_STARTED);
    check("merge_ec", empty_count, 3'd2);
    tick;
    check("idle1_s1", burst_state[1], B_STARTED);
    tick;
    check("idle2_s1", burst_state[1], B_FULL);
    check("s1_type", burst_type[1], R_READ);
    check("s1_addr", burst_address[1], 12'h0AB);
    svc(2);
    check("done_on_empty", burst_state[2], B_EMPTY);
    check("done_on_empty_ec", empty_count, 3'd2);
    mem_rd_valid = 1'b1;
    mem_rd_burst = 2'd1;
    mem_rd_beat = 4'd15;
    mem_rd_last = 1'b1;
    tick;
    mem_rd_valid = 1'b0;
    mem_rd_last = 1'b0;
    check("beat_before_done", burst_state[1], B_FULL);
    svc(1);
    check("read_done_full", burst_state[1], B_FULL);
    for (int b = 0; b < 16; b++) begin
      mem_rd_valid = 1'b1;
      mem_rd_burst = 2'd1;
      mem_rd_beat = 4'(b);
      mem_rd_data = b == 2 ? 32'hAA : b == 9 ? 32'hBB : $urandom;
      mem_rd_last = (b == 15);
      tick;
    end
    mem_rd_valid = 1'b0;
    mem_rd_last = 1'b0;
    check("read_returning", burst_state[1], B_RETURNING);
    expect_ret(1'b0, 4'd2, 32'hAA);
    expect_ret(1'b0, 4'd9, 32'hBB);
    check("read_freed", burst_state[1], B_EMPTY);
    svc(0);
    expect_ret(1'b1, 4'd5, 32'hD3);
    check("write_freed", burst_state[0], B_EMPTY);
    check("all_free_ec", empty_count, 3'd4);
    // all slots occupied: a new address must wait for a slot to drain
    for (int s = 0; s < 4; s++) begin
      d3[s] = $urandom;
      i3[s] = 4'(s + 1);
      send(12'h100 + 12'(s), 4'd0, 1'b1, d3[s], i3[s]);
    end
    for (int s = 0; s < 3; s++) check("fill4_full", burst_state[s], B_FULL);
    check("fill4_open", burst_state[3], B_STARTED);
    check("fill4_ec", empty_count, 3'd0);
    arb_valid = 1'b1;
    arb_address = {12'h200, 4'h0};
    arb_type = R_WRITE;
    arb_data = 32'h2000;
    arb_index = 4'hE;
    for (int k = 0; k < 3; k++) begin
      check("ready_low", arb_ready, 1'b0);
      tick;
    end
    check("fill4_timeout", burst_state[3], B_FULL);
    done_valid = 1'b1;
    done_burst = 2'd2;
    check("ready_low_done", arb_ready, 1'b0);
    tick;
    done_valid = 1'b0;
    expect_ret(1'b1, i3[2], d3[2]);
    check("freed_s2", burst_state[2], B_EMPTY);
    check("freed_ec", empty_count, 3'd1);
    check("freed_ready", arb_ready, 1'b1);
    tick;
    arb_valid = 1'b0;
    check("reuse_s2", burst_state[2], B_STARTED);
    check("reuse_addr", burst_address[2], 12'h200);
    check("reuse_ec", empty_count, 3'd0);
    // stalled returner, then a free and an allocate on the same edge
    svc(1);
    expect_ret(1'b1, i3[1], d3[1]);
    check("s1_free_ec", empty_count, 3'd1);
    ret_ready = 1'b0;
    svc(0);
    wait_ret;
    for (int k = 0; k < 3; k++) begin
      check("stall_valid", ret_valid, 1'b1);
      check("stall_type", ret_type, R_WRITE);
      check("stall_index", ret_index, i3[0]);
      check("stall_data", ret_data, d3[0]);
      tick;
    end
    arb_valid = 1'b1;
    arb_address = {12'h300, 4'h4};
    arb_type = R_READ;
    arb_index = 4'd3;
    ret_ready = 1'b1;
    tick;
    arb_valid = 1'b0;
    check("swap_ec", empty_count, 3'd1);
    check("swap_s0", burst_state[0], B_EMPTY);
    check("swap_s1", burst_state[1], B_STARTED);
    check("swap_ret_valid", ret_valid, 1'b0);
    // reset while slot 2 is returning
    ret_ready = 1'b0;
    svc(2);
    wait_ret;
    check("pre_rst_s2", burst_state[2], B_RETURNING);
    check("pre_rst_valid", ret_valid, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    ret_ready = 1'b1;
    check_reset("mid_reset");
    // a repeated column opens a new slot
    send(12'h055, 4'd5, 1'b1, 32'h1, 4'd1);
    send(12'h055, 4'd5, 1'b1, 32'h2, 4'd2);
    check("dup_s0", burst_state[0], B_FULL);
    check("dup_s1", burst_state[1], B_STARTED);
    check("dup_ec", empty_count, 3'd2);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("dup_reset_ec", empty_count, 3'd4);
    for (int r = 0; r < 12; r++) begin
      logic [15:0] m = ($urandom % 4 == 0) ? 16'hFFFF : 16'($urandom);
      if (m == 16'h0) m = 16'h0001;
      burst(12'($urandom), 1'($urandom), m, 1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
